// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_slave_pkg;

    localparam int SPI_FRAME_W = 10;
    localparam int SPI_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads a read byte and shifts it out MSB first on miso, then returns miso to 0.
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_abort,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    // Bits still to be sent after the MSB that goes out on the load edge.
    logic [DATA_W-2:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_miso;
    logic              r_done;

    // Load / shift / abort sequencing; abort wins over an ongoing shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_abort) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == LAST_CNT) begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_miso  <= r_shift[DATA_W-2];
                r_shift <= {r_shift[DATA_W-3:0], 1'b0};
                r_cnt   <= r_cnt + 1'b1;
                r_done  <= 1'b0;
            end
        end else if (i_load) begin
            r_miso  <= i_data[DATA_W-1];
            r_shift <= i_data[DATA_W-2:0];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_miso <= 1'b0;
            r_done <= 1'b0;
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises command frames for the RAM and
// serialises the RAM read byte back on miso.
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 2);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_bit_cnt;
    // Holds every frame bit received so far except the one on the final edge.
    logic [FRAME_W-2:0] r_shift;
    logic               r_frame_done;
    logic               r_rd_addr_done;
    logic               r_resp_done;

    logic w_in_frame;
    logic w_last_edge;
    logic w_load;
    logic w_tx_busy;
    logic w_tx_done;

    assign w_in_frame  = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
    assign w_last_edge = w_in_frame && !ss_n && !r_frame_done && (r_bit_cnt == LAST_BIT);
    // One response per READ_DATA frame, only after the frame completed.
    assign w_load      = (r_state == READ_DATA) && !ss_n && r_frame_done && !r_resp_done
                         && !w_tx_busy && tx_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: routing uses only the first frame bit and the read-address flag.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!ss_n) begin
                    w_next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (ss_n) begin
                    w_next_state = IDLE;
                end else if (mosi != CMD_RD_ADDR[1]) begin
                    w_next_state = WRITE;
                end else if (r_rd_addr_done) begin
                    w_next_state = READ_DATA;
                end else begin
                    w_next_state = READ_ADD;
                end
            end
            default: begin
                if (ss_n) begin
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    // Frame capture, rx strobe and read-address flag bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_done <= 1'b0;
            r_resp_done    <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((r_state == CHK_CMD) && !ss_n) begin
                r_shift      <= {{(FRAME_W-2){1'b0}}, mosi};
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_resp_done  <= 1'b0;
            end else if (w_in_frame && !ss_n && !r_frame_done) begin
                r_shift <= {r_shift[FRAME_W-3:0], mosi};
                if (w_last_edge) begin
                    rx_data      <= {r_shift, mosi};
                    rx_valid     <= 1'b1;
                    r_frame_done <= 1'b1;
                    if (r_state == READ_ADD) begin
                        r_rd_addr_done <= 1'b1;
                    end else if (r_state == READ_DATA) begin
                        r_rd_addr_done <= 1'b0;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
            if (w_tx_done) begin
                r_resp_done <= 1'b1;
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (tx_data),
        .i_abort (ss_n),
        .o_miso  (miso),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end that sits directly upstream of the single-port byte RAM.
- Deserialises 10-bit MOSI frames (MSB first) into a parallel word for the RAM, delivered on rx_data with a one-cycle rx_valid pulse.
- Serialises the RAM read byte (tx_data/tx_valid) back out on MISO, MSB first.
- SPI bit clock equals the system clock: one bit per clk while ss_n is low.

Parameters:
- FRAME_W, 10, bits per command frame; bits [9:8] are the command, [7:0] the payload.
- DATA_W, 8, width of the read byte returned on MISO.

Ports:
- clk  in  1  system and SPI bit clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ss_n  in  1  slave select, active-low; frame boundary.
- mosi  in  1  serial data in, sampled on the rising edge of clk.
- miso  out  1  serial data out, registered.
- rx_data  out  FRAME_W  assembled frame to the RAM; held until the next frame completes.
- rx_valid  out  1  one-cycle strobe: rx_data is a new complete frame.
- tx_data  in  DATA_W  read byte from the RAM.
- tx_valid  in  1  tx_data valid strobe from the RAM.

Behaviour:
- Reset (rst=1 at a clk edge; highest priority, also mid-frame):
  - state=IDLE; miso=0, rx_data=0, rx_valid=0.
  - rd_addr_done flag=0, bit counter=0, shift registers=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- In every state except IDLE, ss_n sampled 1 sends the FSM to IDLE at the next edge.
  - Partial frame is discarded: no rx_valid, flag unchanged, miso=0 from that edge.
- IDLE:
  - ss_n=0 -> CHK_CMD.
  - mosi is ignored.
- CHK_CMD: the edge samples mosi as frame bit 9.
  - bit9=0 -> WRITE.
  - bit9=1, flag=0 -> READ_ADD.
  - bit9=1, flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Next 9 edges sample bits 8..0 into the shift register.
  - On the edge sampling bit 0: rx_data <= full 10-bit frame, rx_valid <= 1 for exactly one cycle.
  - Timing: if ss_n is first sampled low at edge k, rx_valid is high in the cycle after edge k+10.
- After the frame completes, mosi is ignored until ss_n rises; there is no back-to-back framing within one ss_n assertion.
- Command bits are forwarded exactly as received.
  - Bit 8 is not checked against the state.
  - The state choice depends only on bit 9 and the flag.
- Flag update:
  - Set to 1 when a READ_ADD frame completes.
  - Cleared to 0 when a READ_DATA frame completes.
- READ_DATA response:
  - After rx_valid, wait indefinitely for tx_valid=1.
  - At the edge sampling tx_valid=1: miso <= tx_data[7], and the remaining bits are loaded.
  - Next 7 edges: miso <= tx_data[6..0]. Next edge: miso <= 0.
- tx_valid is ignored in every other state/phase, and during an active shift-out.
- ss_n rising during shift-out aborts it: miso <= 0 at the edge ss_n=1 is sampled.
- miso is 0 whenever not shifting read data.
- Bit counter: 4-bit, counts 0..8 within a frame, reset on CHK_CMD entry. The shift-out counter is 3-bit.

Decomposition:
- Package spi_slave_pkg:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W, DATA_W defaults.
- One sub-module, spi_tx_serializer: load/shift DATA_W register with a done indication. It drives miso.

Test Plan:
- Reset mid-frame: ss_n=0, 5 bits sent, rst=1 one cycle -> all outputs 0, state IDLE, no rx_valid; next full frame is received correctly.
- Write address: ss_n=0, send 10'b00_1010_0101 -> rx_valid one cycle at edge k+10 with rx_data=10'h0A5; miso stays 0.
- Write data: send 10'b01_0011_1100 -> rx_data=10'h13C, rx_valid single pulse; flag remains 0.
- Read sequence:
  - Send 10'b10_0000_0111 -> rx_data=10'h207 and flag=1.
  - New ss_n frame 10'b11_xxxx_xxxx -> routes to READ_DATA, rx_valid pulses, flag=0.
  - Drive tx_valid with tx_data=8'hC3 one cycle later -> miso 1,1,0,0,0,0,1,1 on successive edges, then 0.
- Abort: ss_n rises after 6 bits of a WRITE frame -> no rx_valid, IDLE next edge; a following READ_ADD frame 10'h2FF completes normally.
- Spurious tx_valid with tx_data=8'hFF while in WRITE -> miso stays 0.
